led_level_sequencer: RTL and testbench

//   Drives the 5-bit level (0..16) consumed by the 16-LED thermometer bar display.

---
 rtl/led_level_sequencer_pkg.sv | 6 +
 rtl/led_level_sequencer_if.sv | 16 +
 rtl/led_level_sequencer_step_tick_gen.sv | 23 ++
 rtl/led_level_sequencer.sv | 64 ++++++
 tb/tb_led_level_sequencer.sv | 120 ++++++++++++
 5 files changed

// File: rtl/led_level_sequencer_pkg.sv
// led_seq_pkg: shared state encoding and level limits for the LED level sequencer and bar decoder.
package led_seq_pkg;
    localparam int LED_MAX_LEVEL = 16;
    localparam int LED_CNT_W     = 5;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_e;
endpackage

// File: rtl/led_level_sequencer_if.sv
// led_level_sequencer_if: control pulses in, level/status out for the LED level sequencer.
interface led_level_sequencer_if
    import led_seq_pkg::*;
#(
    parameter int CNT_W = LED_CNT_W
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             dir_toggle;
    logic [CNT_W-1:0] counter_out;
    logic             running;
    logic             dir_down;
    modport master (output start, stop, clear, dir_toggle, input counter_out, running, dir_down);
    modport slave (input start, stop, clear, dir_toggle, output counter_out, running, dir_down);
endinterface

// File: rtl/led_level_sequencer_step_tick_gen.sv
// step_tick_gen: prescaler counting 0..TICK_DIV-1 while enabled, one-cycle tick on the last count.
module step_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d  = (clr_i || !en_i) ? '0 : (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        cnt_d  = (!clr_i && !en_i) ? cnt_q : cnt_d;
        tick_o = en_i && !clr_i && (cnt_q == LAST);
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_level_sequencer.sv
// led_level_sequencer: steps the LED bar level up/down at a prescaled rate under start/stop/clear/dir control.
// AUTO_BOUNCE_EN selects ping-pong at the endpoints instead of saturation.
module led_level_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_LEVEL = LED_MAX_LEVEL,
    parameter int CNT_W     = LED_CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    led_level_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] TOP = CNT_W'(MAX_LEVEL);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] level_q, level_d, level_step;
    logic             dir_q, dir_d, running_q, running_d;
    logic             tick, step, at_end, bounce;
    step_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_RUN),
        .clr_i  (state_q != ST_RUN),
        .tick_o (tick)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            level_q   <= '0;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            dir_q     <= dir_d;
            running_q <= running_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (bus.clear)      state_d = ST_IDLE;
        else if (bus.stop)  state_d = (state_q == ST_RUN) ? ST_HOLD : state_q;
        else if (bus.start) state_d = ST_RUN;
    end
    // A step coinciding with stop or clear is dropped; direction toggles still apply.
    always_comb begin
        step   = tick && !bus.stop && !bus.clear;
        at_end = dir_q ? (level_q == '0) : (level_q == TOP);
`ifdef AUTO_BOUNCE_EN
        bounce     = step && at_end;
        level_step = at_end ? (dir_q ? ONE : TOP - ONE) : (dir_q ? level_q - ONE : level_q + ONE);
`else
        bounce     = 1'b0;
        level_step = at_end ? level_q : (dir_q ? level_q - ONE : level_q + ONE);
`endif
        level_d   = bus.clear ? '0 : step ? level_step : level_q;
        dir_d     = bus.clear ? 1'b0 : dir_q ^ bus.dir_toggle ^ bounce;
        running_d = (state_d == ST_RUN);
    end
    assign bus.counter_out = level_q;
    assign bus.running     = running_q;
    assign bus.dir_down    = dir_q;
endmodule

// File: tb/tb_led_level_sequencer.sv
// tb_led_level_sequencer: directed bench for the LED level sequencer with TICK_DIV=4.
module tb_led_level_sequencer;
    import led_seq_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    led_level_sequencer_if bus ();
    led_level_sequencer #(.TICK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    initial begin
        bus.start = 1'b1; bus.stop = 1'b0; bus.clear = 1'b0; bus.dir_toggle = 1'b0;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_level", int'(bus.counter_out), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_dir", int'(bus.dir_down), 0);
        chk("rst_state", int'(dut.state_q), int'(ST_IDLE));
        // count up: start in cycle 0
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("up_running_c1", int'(bus.running), 1);
        chk("up_level_c1", int'(bus.counter_out), 0);
        cyc(3);
        chk("up_level_c4", int'(bus.counter_out), 0);
        cyc();
        chk("up_level_c5", int'(bus.counter_out), 1);
        cyc(4);
        chk("up_level_c9", int'(bus.counter_out), 2);
        cyc(4);
        chk("up_level_c13", int'(bus.counter_out), 3);
        cyc(8);
        chk("up_level_c21", int'(bus.counter_out), 5);
        // pause at 5, hold 20 cycles, resume
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        chk("hold_running", int'(bus.running), 0);
        chk("hold_state", int'(dut.state_q), int'(ST_HOLD));
        cyc(20);
        chk("hold_level", int'(bus.counter_out), 5);
        chk("hold_running_late", int'(bus.running), 0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("resume_running", int'(bus.running), 1);
        cyc(3);
        chk("resume_level_pre", int'(bus.counter_out), 5);
        cyc();
        chk("resume_level_6", int'(bus.counter_out), 6);
        // stop exactly on the step cycle drops the step
        cyc(3);
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        chk("stop_step_level", int'(bus.counter_out), 6);
        chk("stop_step_running", int'(bus.running), 0);
        cyc(4);
        chk("stop_step_hold", int'(bus.counter_out), 6);
        // dir_toggle on the step cycle: step uses old direction
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        cyc(3);
        bus.dir_toggle = 1'b1; cyc(); bus.dir_toggle = 1'b0;
        chk("tog_step_level", int'(bus.counter_out), 7);
        chk("tog_step_dir", int'(bus.dir_down), 1);
        cyc(4);
        chk("down_level", int'(bus.counter_out), 6);
        bus.dir_toggle = 1'b1; cyc(); bus.dir_toggle = 1'b0;
        chk("tog_back_dir", int'(bus.dir_down), 0);
        chk("tog_back_level", int'(bus.counter_out), 6);
        cyc(11);
        chk("reach_9", int'(bus.counter_out), 9);
        // clear beats stop and dir_toggle
        bus.clear = 1'b1; bus.stop = 1'b1; bus.dir_toggle = 1'b1; cyc();
        bus.clear = 1'b0; bus.stop = 1'b0; bus.dir_toggle = 1'b0;
        chk("prio_level", int'(bus.counter_out), 0);
        chk("prio_dir", int'(bus.dir_down), 0);
        chk("prio_running", int'(bus.running), 0);
        chk("prio_state", int'(dut.state_q), int'(ST_IDLE));
        bus.dir_toggle = 1'b1; cyc(); bus.dir_toggle = 1'b0;
        chk("idle_tog_dir", int'(bus.dir_down), 1);
        bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
        chk("idle_clear_dir", int'(bus.dir_down), 0);
        // run to the top endpoint
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        cyc(63);
        chk("top_minus1", int'(bus.counter_out), 15);
        cyc();
        chk("top_16", int'(bus.counter_out), 16);
`ifdef AUTO_BOUNCE_EN
        cyc(4);
        chk("bounce_15", int'(bus.counter_out), 15);
        chk("bounce_dir", int'(bus.dir_down), 1);
        cyc(4);
        chk("bounce_14", int'(bus.counter_out), 14);
        cyc(4);
        chk("bounce_13", int'(bus.counter_out), 13);
`else
        cyc(80);
        chk("sat_level", int'(bus.counter_out), 16);
        chk("sat_running", int'(bus.running), 1);
        chk("sat_dir", int'(bus.dir_down), 0);
`endif
        // reset mid-run wins over start
        rst = 1'b1; bus.start = 1'b1; cyc(); rst = 1'b0; bus.start = 1'b0;
        chk("midrst_level", int'(bus.counter_out), 0);
        chk("midrst_running", int'(bus.running), 0);
        chk("midrst_dir", int'(bus.dir_down), 0);
        chk("midrst_state", int'(dut.state_q), int'(ST_IDLE));
        cyc(6);
        chk("midrst_idle_level", int'(bus.counter_out), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
